// File: rtl/calc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : calc_pkg                                                       |
// | Purpose   : Shared types and op codes for the RPN stack calculator.        |
// |             oper    - key type on the op input (one-hot, 0 = none)         |
// |             state_t - sequencing FSM states                                |
// |             OP_*    - one-hot arithOp codes carried in payload[15:0]       |
// | Config    : RPN_CALC_MUL_EN enables the signed MUL code (0x200).           |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package calc_pkg;

  typedef enum logic [3:0] {
    OPER_NONE  = 4'd0,
    OPER_START = 4'd1,
    OPER_ENTER = 4'd2,
    OPER_ARITH = 4'd4,
    OPER_DONE  = 4'd8
  } oper;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // Op codes occupy the low 16 payload bits; higher payload bits must be zero.
  localparam int unsigned OPCODE_W = 16;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 16'h0001;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 16'h0002;
  localparam logic [OPCODE_W-1:0] OP_AND  = 16'h0004;
  localparam logic [OPCODE_W-1:0] OP_SWAP = 16'h0008;
  localparam logic [OPCODE_W-1:0] OP_NEG  = 16'h0010;
  localparam logic [OPCODE_W-1:0] OP_POP  = 16'h0020;
  localparam logic [OPCODE_W-1:0] OP_OR   = 16'h0040;
  localparam logic [OPCODE_W-1:0] OP_XOR  = 16'h0080;
  localparam logic [OPCODE_W-1:0] OP_DUP  = 16'h0100;
  localparam logic [OPCODE_W-1:0] OP_MUL  = 16'h0200;

`ifdef RPN_CALC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

endpackage : calc_pkg
`default_nettype wire

// File: rtl/calc_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : calc_alu                                                       |
// | Purpose   : Combinational datapath for the RPN calculator. a is the top of |
// |             stack, b the entry below it. Results wrap modulo 2^WIDTH and   |
// |             ovf flags two's-complement overflow for ADD/SUB/NEG/MUL.       |
// | Ports     : a, b    in  WIDTH    operands                                  |
// |             opcode  in  16       one-hot op code                           |
// |             value   out WIDTH    wrapped result                            |
// |             ovf     out 1        signed overflow                           |
// | Config    : RPN_CALC_MUL_EN builds the multiplier; otherwise none exists.  |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module calc_alu
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [WIDTH-1:0]    value,
  output logic                ovf
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] mul_value;
  logic             mul_ovf;

`ifdef RPN_CALC_MUL_EN
  // Sign-extended operands multiplied at double width give the exact signed
  // product; it fits WIDTH bits only if its top WIDTH+1 bits are all equal.
  logic [2*WIDTH-1:0] product;
  assign product   = {{WIDTH{a[MSB]}}, a} * {{WIDTH{b[MSB]}}, b};
  assign mul_value = product[WIDTH-1:0];
  assign mul_ovf   = !((&product[2*WIDTH-1:MSB]) || !(|product[2*WIDTH-1:MSB]));
`else
  assign mul_value = '0;
  assign mul_ovf   = 1'b0;
`endif

  always_comb begin
    value = '0;
    ovf   = 1'b0;
    case (opcode)
      OP_ADD: begin
        value = a + b;
        ovf   = (a[MSB] == b[MSB]) && (value[MSB] != a[MSB]);
      end
      OP_SUB: begin
        value = b - a;
        ovf   = (a[MSB] != b[MSB]) && (value[MSB] != b[MSB]);
      end
      OP_AND: value = a & b;
      OP_OR:  value = a | b;
      OP_XOR: value = a ^ b;
      OP_NEG: begin
        value = '0 - a;
        // Only the most negative value has no positive counterpart.
        ovf   = a[MSB] && (a[MSB-1:0] == '0);
      end
      OP_MUL: begin
        value = mul_value;
        ovf   = mul_ovf;
      end
      default: begin
        value = '0;
        ovf   = 1'b0;
      end
    endcase
  end

endmodule : calc_alu
`default_nettype wire

// File: rtl/rpn_stack_calc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : rpn_stack_calc                                                 |
// | Purpose   : RPN stack calculator taking one key per clock. Keeps an        |
// |             operand stack (entry 0 = top), sequences start/enter/arith/    |
// |             done keys and reports sticky error flags on completion.        |
// | Ports     : ck             in  1      clock                                |
// |             rst            in  1      synchronous active-high reset        |
// |             op             in  4      key type (oper)                      |
// |             payload        in  WIDTH  operand or one-hot op code           |
// |             result         out WIDTH  top of stack, 0 when empty           |
// |             depth          out CNT_W  stack occupancy                      |
// |             stackOverflow  out 1      push at full stack                   |
// |             dataOverflow   out 1      signed arithmetic overflow           |
// |             protocolError  out 1      bad key sequence/code/underflow      |
// |             unexpectedDone out 1      done with depth != 1                 |
// |             finished       out 1      one-cycle pulse after done           |
// |             correct        out 1      finished with no flag set            |
// | Config    : RPN_CALC_MUL_EN enables arithOp 0x200 (signed MUL).            |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module rpn_stack_calc
  import calc_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] payload,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] depth,
  output logic             stackOverflow,
  output logic             dataOverflow,
  output logic             protocolError,
  output logic             unexpectedDone,
  output logic             finished,
  output logic             correct
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stack_ovf_q, stack_ovf_d;
  logic             data_ovf_q, data_ovf_d;
  logic             proto_err_q, proto_err_d;
  logic             unexp_done_q, unexp_done_d;
  logic             finished_q, finished_d;
  logic             correct_q, correct_d;

  // Candidate next stacks, precomputed so the FSM just selects one.
  logic [WIDTH-1:0] push_val;
  logic [WIDTH-1:0] push_stack  [DEPTH];
  logic [WIDTH-1:0] pop_stack   [DEPTH];
  logic [WIDTH-1:0] start_stack [DEPTH];

  logic [OPCODE_W-1:0] opcode;
  logic                code_bin, code_un, code_legal;
  logic [WIDTH-1:0]    alu_value;
  logic                alu_ovf;
  logic                any_flag;

  assign opcode   = payload[OPCODE_W-1:0];
  assign any_flag = stack_ovf_q | data_ovf_q | proto_err_q | unexp_done_q;
  // DUP re-pushes the current top; enter pushes the payload.
  assign push_val = (op == OPER_ENTER) ? payload : stack_q[0];

  always_comb begin
    push_stack[0]  = push_val;
    start_stack[0] = payload;
    for (int i = 1; i < DEPTH; i++) begin
      push_stack[i]  = stack_q[i-1];
      start_stack[i] = '0;
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      pop_stack[i] = stack_q[i+1];
    end
    // Vacated entries are zeroed so an empty stack reads 0 at the top.
    pop_stack[DEPTH-1] = '0;
  end

  // Op code classification: binary ops (and SWAP) need two operands,
  // unary ones need one. Any payload bit above the code field makes it illegal.
  always_comb begin
    code_bin = 1'b0;
    code_un  = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_SWAP, OP_OR, OP_XOR: code_bin = 1'b1;
      OP_NEG, OP_POP, OP_DUP:                         code_un  = 1'b1;
      OP_MUL:                                         code_bin = MUL_EN;
      default: begin
        code_bin = 1'b0;
        code_un  = 1'b0;
      end
    endcase
    code_legal = ((payload >> OPCODE_W) == '0) && (code_bin || code_un);
  end

  calc_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a      (stack_q[0]),
    .b      (stack_q[1]),
    .opcode (opcode),
    .value  (alu_value),
    .ovf    (alu_ovf)
  );

  always_comb begin
    state_d      = state_q;
    stack_d      = stack_q;
    cnt_d        = cnt_q;
    stack_ovf_d  = stack_ovf_q;
    data_ovf_d   = data_ovf_q;
    proto_err_d  = proto_err_q;
    unexp_done_d = unexp_done_q;
    finished_d   = 1'b0;
    correct_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        case (op)
          OPER_NONE: ;
          OPER_START: begin
            stack_d = start_stack;
            cnt_d   = CNT_ONE;
            state_d = ST_ACTIVE;
          end
          OPER_DONE: begin
            proto_err_d = 1'b1;
            finished_d  = 1'b1;
            state_d     = ST_REPORT;
          end
          default: begin
            proto_err_d = 1'b1;
            state_d     = ST_ACTIVE;
          end
        endcase
      end

      ST_ACTIVE: begin
        case (op)
          OPER_NONE: ;
          OPER_ENTER: begin
            if (!any_flag) begin
              if (cnt_q == CNT_FULL) begin
                stack_ovf_d = 1'b1;
              end else begin
                stack_d = push_stack;
                cnt_d   = cnt_q + CNT_ONE;
              end
            end
          end
          OPER_ARITH: begin
            if (!any_flag) begin
              if (!code_legal || (code_bin && (cnt_q < CNT_TWO)) ||
                  (code_un && (cnt_q == '0))) begin
                proto_err_d = 1'b1;
              end else begin
                case (opcode)
                  OP_SWAP: begin
                    stack_d[0] = stack_q[1];
                    stack_d[1] = stack_q[0];
                  end
                  OP_POP: begin
                    stack_d = pop_stack;
                    cnt_d   = cnt_q - CNT_ONE;
                  end
                  OP_DUP: begin
                    if (cnt_q == CNT_FULL) begin
                      stack_ovf_d = 1'b1;
                    end else begin
                      stack_d = push_stack;
                      cnt_d   = cnt_q + CNT_ONE;
                    end
                  end
                  OP_NEG: begin
                    stack_d[0] = alu_value;
                    data_ovf_d = alu_ovf;
                  end
                  default: begin
                    // Binary op: consume two operands, push the wrapped result.
                    stack_d    = pop_stack;
                    stack_d[0] = alu_value;
                    cnt_d      = cnt_q - CNT_ONE;
                    data_ovf_d = alu_ovf;
                  end
                endcase
              end
            end
          end
          OPER_DONE: begin
            unexp_done_d = (cnt_q != CNT_ONE);
            finished_d   = 1'b1;
            correct_d    = !(any_flag || (cnt_q != CNT_ONE));
            state_d      = ST_REPORT;
          end
          default: proto_err_d = 1'b1;
        endcase
      end

      default: begin
        // Report cycle ends: everything clears, and a start here opens a new sequence.
        stack_ovf_d  = 1'b0;
        data_ovf_d   = 1'b0;
        proto_err_d  = 1'b0;
        unexp_done_d = 1'b0;
        if (op == OPER_START) begin
          stack_d = start_stack;
          cnt_d   = CNT_ONE;
          state_d = ST_ACTIVE;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            stack_d[i] = '0;
          end
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      stack_ovf_q  <= 1'b0;
      data_ovf_q   <= 1'b0;
      proto_err_q  <= 1'b0;
      unexp_done_q <= 1'b0;
      finished_q   <= 1'b0;
      correct_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stack_ovf_q  <= stack_ovf_d;
      data_ovf_q   <= data_ovf_d;
      proto_err_q  <= proto_err_d;
      unexp_done_q <= unexp_done_d;
      finished_q   <= finished_d;
      correct_q    <= correct_d;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end

  assign result         = stack_q[0];
  assign depth          = cnt_q;
  assign stackOverflow  = stack_ovf_q;
  assign dataOverflow   = data_ovf_q;
  assign protocolError  = proto_err_q;
  assign unexpectedDone = unexp_done_q;
  assign finished       = finished_q;
  assign correct        = correct_q;

endmodule : rpn_stack_calc
`default_nettype wire

// File: tb/tb_rpn_stack_calc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_rpn_stack_calc                                              |
// | Purpose   : Self-checking bench for rpn_stack_calc. A queue-based model    |
// |             predicts every output after every key; directed sequences are  |
// |             followed by randomized keys, operands, op codes and resets.    |
// | Config    : RPN_CALC_MUL_EN selects whether 0x200 is modelled as MUL.      |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_rpn_stack_calc;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int CW = $clog2(D + 1);

`ifdef RPN_CALC_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  localparam longint MAXS = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINS = -(longint'(1) <<< (W - 1));

  logic          ck = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    op = 4'd0;
  logic [W-1:0]  payload = '0;
  logic [W-1:0]  result;
  logic [CW-1:0] depth;
  logic          so, dov, pe, ud, fin, cor;

  rpn_stack_calc #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .ck             (ck),
    .rst            (rst),
    .op             (op),
    .payload        (payload),
    .result         (result),
    .depth          (depth),
    .stackOverflow  (so),
    .dataOverflow   (dov),
    .protocolError  (pe),
    .unexpectedDone (ud),
    .finished       (fin),
    .correct        (cor)
  );

  always #5 ck = ~ck;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_ACTIVE, M_REPORT} mstate_t;
  mstate_t      m_st;
  logic [W-1:0] stk[$];          // stk[0] is the top of stack
  bit           m_so, m_dov, m_pe, m_ud, m_fin, m_cor;

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic bit out_of_range(input longint s);
    return (s > MAXS) || (s < MINS);
  endfunction

  task automatic m_reset();
    m_st = M_IDLE;
    stk.delete();
    {m_so, m_dov, m_pe, m_ud, m_fin, m_cor} = '0;
  endtask

  task automatic m_push(input logic [W-1:0] v);
    if (stk.size() == D) m_so = 1'b1;
    else stk.push_front(v);
  endtask

  task automatic m_replace2(input logic [W-1:0] v);
    void'(stk.pop_front());
    void'(stk.pop_front());
    stk.push_front(v);
  endtask

  task automatic m_arith(input logic [W-1:0] code);
    int           need;
    bit           legal;
    longint       s;
    logic [W-1:0] a, b;
    legal = 1'b1;
    need  = 2;
    case (code)
      16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0040, 16'h0080: need = 2;
      16'h0010, 16'h0020, 16'h0100: need = 1;
      16'h0200: legal = MUL_ON;
      default:  legal = 1'b0;
    endcase
    if (!legal || stk.size() < need) begin
      m_pe = 1'b1;
      return;
    end
    a = stk[0];
    b = (need == 2) ? stk[1] : '0;
    case (code)
      16'h0001: begin s = sx(a) + sx(b); m_dov = out_of_range(s); m_replace2(s[W-1:0]); end
      16'h0002: begin s = sx(b) - sx(a); m_dov = out_of_range(s); m_replace2(s[W-1:0]); end
      16'h0200: begin s = sx(a) * sx(b); m_dov = out_of_range(s); m_replace2(s[W-1:0]); end
      16'h0004: m_replace2(a & b);
      16'h0040: m_replace2(a | b);
      16'h0080: m_replace2(a ^ b);
      16'h0008: begin stk[0] = b; stk[1] = a; end
      16'h0010: begin s = -sx(a); m_dov = out_of_range(s); stk[0] = s[W-1:0]; end
      16'h0020: void'(stk.pop_front());
      default:  m_push(a);   // DUP
    endcase
  endtask

  task automatic m_step(input logic [3:0] o, input logic [W-1:0] p);
    bit anyf;
    anyf  = m_so | m_dov | m_pe | m_ud;
    m_fin = 1'b0;
    m_cor = 1'b0;
    case (m_st)
      M_IDLE: begin
        if (o == 4'd1) begin
          stk.delete();
          stk.push_front(p);
          m_st = M_ACTIVE;
        end else if (o == 4'd8) begin
          m_pe  = 1'b1;
          m_fin = 1'b1;
          m_st  = M_REPORT;
        end else if (o != 4'd0) begin
          m_pe = 1'b1;
          m_st = M_ACTIVE;
        end
      end
      M_ACTIVE: begin
        if (o == 4'd2) begin
          if (!anyf) m_push(p);
        end else if (o == 4'd4) begin
          if (!anyf) m_arith(p);
        end else if (o == 4'd8) begin
          if (stk.size() != 1) m_ud = 1'b1;
          m_fin = 1'b1;
          m_st  = M_REPORT;
        end else if (o != 4'd0) begin
          m_pe = 1'b1;
        end
      end
      default: begin
        {m_so, m_dov, m_pe, m_ud} = '0;
        stk.delete();
        if (o == 4'd1) begin
          stk.push_front(p);
          m_st = M_ACTIVE;
        end else begin
          m_st = M_IDLE;
        end
      end
    endcase
    if (m_fin) m_cor = !(m_so | m_dov | m_pe | m_ud);
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h required 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [W-1:0] top;
    top = (stk.size() == 0) ? '0 : stk[0];
    check("result",         64'(result), 64'(top));
    check("depth",          64'(depth),  64'(stk.size()));
    check("stackOverflow",  64'(so),     64'(m_so));
    check("dataOverflow",   64'(dov),    64'(m_dov));
    check("protocolError",  64'(pe),     64'(m_pe));
    check("unexpectedDone", 64'(ud),     64'(m_ud));
    check("finished",       64'(fin),    64'(m_fin));
    check("correct",        64'(cor),    64'(m_cor));
  endtask

  task automatic key(input logic [3:0] o, input logic [W-1:0] p);
    op      = o;
    payload = p;
    @(posedge ck);
    m_step(o, p);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    op      = 4'($urandom_range(0, 15));
    payload = W'($urandom);
    @(posedge ck);
    m_reset();
    #1;
    check_all();
    rst = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [W-1:0] rand_code();
    int r;
    r = $urandom_range(0, 19);
    if (r <= 9)       return W'(1 << r);
    else if (r <= 13) return W'($urandom_range(1, 2));
    else if (r == 14) return W'($urandom);
    else if (r == 15) return '0;
    else if (r == 16) return 16'h0400;
    else              return W'(1 << (r - 17));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] bad;
    int         r;
    m_reset();
    do_reset();
    do_reset();
    check("reset_result", 64'(result), 64'd0);

    // ADD then a clean done
    key(4'd1, 16'd3); key(4'd2, 16'd5); key(4'd4, 16'h0001);
    check("t1_add", 64'(result), 64'd8);
    key(4'd8, 16'd0);
    check("t1_finished", 64'(fin), 64'd1);
    check("t1_correct",  64'(cor), 64'd1);
    key(4'd0, 16'd0);

    // SUB overflow stays visible through done
    key(4'd1, 16'h8000); key(4'd2, 16'd1); key(4'd4, 16'h0002);
    check("t2_sub", 64'(result), 64'h7FFF);
    check("t2_ovf", 64'(dov),    64'd1);
    key(4'd2, 16'd9);
    check("t2_frozen", 64'(result), 64'h7FFF);
    key(4'd8, 16'd0);
    check("t2_correct", 64'(cor), 64'd0);
    key(4'd0, 16'd0);

    // Fill to DEPTH, then one more push
    key(4'd1, 16'd1);
    for (int i = 0; i < D; i++) key(4'd2, 16'd1);
    check("t3_so",    64'(so),     64'd1);
    check("t3_depth", 64'(depth),  64'(D));
    check("t3_top",   64'(result), 64'd1);
    key(4'd8, 16'd0); key(4'd0, 16'd0);

    // start mid-sequence
    key(4'd1, 16'd7); key(4'd2, 16'd2); key(4'd1, 16'd7);
    check("t4_pe", 64'(pe), 64'd1);
    key(4'd8, 16'd0);
    check("t4_pe_done", 64'(pe), 64'd1);
    key(4'd0, 16'd0);
    check("t4_pe_clear", 64'(pe), 64'd0);

    // done with two operands on the stack
    key(4'd1, 16'd21); key(4'd2, 16'd18); key(4'd8, 16'd0);
    check("t5_ud",  64'(ud),  64'd1);
    check("t5_fin", 64'(fin), 64'd1);
    check("t5_cor", 64'(cor), 64'd0);
    key(4'd0, 16'd0);

    // DUP then XOR, plus the MUL code
    key(4'd1, 16'd9); key(4'd4, 16'h0100); key(4'd4, 16'h0080);
    check("t6_dupxor", 64'(result), 64'd0);
    key(4'd8, 16'd0);
    key(4'd1, 16'h0100); key(4'd2, 16'h0100); key(4'd4, 16'h0200);
    key(4'd8, 16'd0);
    key(4'd1, 16'd4);   // start accepted directly from the report cycle
    key(4'd8, 16'd0); key(4'd0, 16'd0);

    // randomized keys
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        do_reset();
      end else if (r < 10) begin
        key(4'd0, rand_operand());
      end else if (r < 22) begin
        key(4'd1, rand_operand());
      end else if (r < 55) begin
        key(4'd2, rand_operand());
      end else if (r < 88) begin
        key(4'd4, rand_code());
      end else if (r < 95) begin
        key(4'd8, rand_operand());
      end else begin
        do bad = 4'($urandom_range(0, 15));
        while (bad == 4'd0 || bad == 4'd1 || bad == 4'd2 || bad == 4'd4 || bad == 4'd8);
        key(bad, rand_operand());
      end
    end

    key(4'd0, 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_rpn_stack_calc
`default_nettype wire
